// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - segment codes, digit indices and field limits for the time display
package clock_disp_pkg;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Scan order: the pointer value doubles as the an_n bit index
  localparam logic [2:0] DIG_SEC_U = 3'd0;
  localparam logic [2:0] DIG_SEC_T = 3'd1;
  localparam logic [2:0] DIG_MIN_U = 3'd2;
  localparam logic [2:0] DIG_MIN_T = 3'd3;
  localparam logic [2:0] DIG_HR_U  = 3'd4;
  localparam logic [2:0] DIG_HR_T  = 3'd5;

  // Largest legal value of each field
  localparam logic [5:0] HR_MAX  = 6'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] SEC_MAX = 6'd59;

  // BCD digit to segment pattern; non-decimal codes show nothing
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_2dig.sv
// rtl/bin2bcd_2dig.sv - combinational 0..63 binary to two BCD digits with range flag
module bin2bcd_2dig (
  input  logic [5:0] value,
  input  logic [5:0] max_val,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       valid
);

  // Divide by a constant; 63/10 fits comfortably in four bits
  assign tens  = 4'(value / 6'd10);
  assign units = 4'(value % 6'd10);
  assign valid = (value <= max_val);

endmodule

// File: rtl/clock_display_driver.sv
// rtl/clock_display_driver.sv - 6-digit multiplexed 7-segment driver for HH.MM.SS
module clock_display_driver
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter bit LEAD_BLANK = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] in_hour,
  input  logic [5:0] in_min,
  input  logic [5:0] in_sec,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n
);

  localparam int               PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [2:0]       dig_ptr;
  logic [4:0]       snap_hour;
  logic [5:0]       snap_min;
  logic [5:0]       snap_sec;

  logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
  logic       hr_ok, min_ok, sec_ok;

  logic [6:0] seg_next;
  logic       dp_next;
  logic [5:0] an_next;

  assign tick = (pre_cnt == PRE_LAST);

  // Prescaler sets how long each digit stays lit
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PRE_W'(1);
  end

  // Digit pointer walks sec units up to hour tens, then wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     dig_ptr <= DIG_SEC_U;
    else if (tick) dig_ptr <= (dig_ptr == DIG_HR_T) ? DIG_SEC_U : dig_ptr + 3'd1;
  end

  // Capture all three fields at once at the frame boundary so a counter carry cannot tear the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_hour <= '0;
      snap_min  <= '0;
      snap_sec  <= '0;
    end else if (tick && (dig_ptr == DIG_HR_T)) begin
      snap_hour <= in_hour;
      snap_min  <= in_min;
      snap_sec  <= in_sec;
    end
  end

  bin2bcd_2dig u_hr (
    .value   ({1'b0, snap_hour}),
    .max_val (HR_MAX),
    .tens    (hr_t),
    .units   (hr_u),
    .valid   (hr_ok)
  );

  bin2bcd_2dig u_min (
    .value   (snap_min),
    .max_val (MIN_MAX),
    .tens    (min_t),
    .units   (min_u),
    .valid   (min_ok)
  );

  bin2bcd_2dig u_sec (
    .value   (snap_sec),
    .max_val (SEC_MAX),
    .tens    (sec_t),
    .units   (sec_u),
    .valid   (sec_ok)
  );

  // Pick the pattern for the digit under the pointer; invalid fields show dashes
  always_comb begin
    seg_next = SEG_BLANK;
    case (dig_ptr)
      DIG_SEC_U: seg_next = sec_ok ? seg_encode(sec_u) : SEG_DASH;
      DIG_SEC_T: seg_next = sec_ok ? seg_encode(sec_t) : SEG_DASH;
      DIG_MIN_U: seg_next = min_ok ? seg_encode(min_u) : SEG_DASH;
      DIG_MIN_T: seg_next = min_ok ? seg_encode(min_t) : SEG_DASH;
      DIG_HR_U:  seg_next = hr_ok  ? seg_encode(hr_u)  : SEG_DASH;
      DIG_HR_T: begin
        if (!hr_ok)                        seg_next = SEG_DASH;
        else if (LEAD_BLANK && hr_t == '0) seg_next = SEG_BLANK;
        else                               seg_next = seg_encode(hr_t);
      end
      default:   seg_next = SEG_BLANK;
    endcase
    // Colon dots sit after the hour and minute units and are lit on even seconds
    dp_next = !(((dig_ptr == DIG_HR_U) || (dig_ptr == DIG_MIN_U)) && !snap_sec[0]);
    an_next = ~(6'b000001 << dig_ptr);
  end

  // Register the pins so segment and anode changes line up on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
      an_n  <= 6'b111111;
    end else begin
      seg_n <= seg_next;
      dp_n  <= dp_next;
      an_n  <= an_next;
    end
  end

endmodule

// File: tb/tb_clock_display_driver.sv
// tb/tb_clock_display_driver.sv - scoreboard bench for clock_display_driver
module tb_clock_display_driver;

  typedef struct {
    int          d;
    int          cyc;
    logic [13:0] exp;
  } item_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] in_hour;
  logic [5:0] in_min;
  logic [5:0] in_sec;

  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic [5:0] an_a, an_b, an_c;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    running = 1'b0;
  item_t sb[$];

  int scan [3] = '{4, 4, 1};
  bit lb   [3] = '{1'b0, 1'b1, 1'b0};
  int sh [3];
  int sm [3];
  int ss [3];

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  clock_display_driver #(.SCAN_DIV(4), .LEAD_BLANK(1'b0)) dut_a (
    .clk(clk), .reset(reset), .in_hour(in_hour), .in_min(in_min), .in_sec(in_sec),
    .seg_n(seg_a), .dp_n(dp_a), .an_n(an_a));

  clock_display_driver #(.SCAN_DIV(4), .LEAD_BLANK(1'b1)) dut_b (
    .clk(clk), .reset(reset), .in_hour(in_hour), .in_min(in_min), .in_sec(in_sec),
    .seg_n(seg_b), .dp_n(dp_b), .an_n(an_b));

  clock_display_driver #(.SCAN_DIV(1), .LEAD_BLANK(1'b0)) dut_c (
    .clk(clk), .reset(reset), .in_hour(in_hour), .in_min(in_min), .in_sec(in_sec),
    .seg_n(seg_c), .dp_n(dp_c), .an_n(an_c));

  // Reference: the n-th edge after release shows position ((n-1)/S)%6 of the time latched at the last frame end
  function automatic logic [13:0] model(int n, int s, bit blank_en, int h, int m, int sc);
    int pos, v, lim, digit;
    logic [6:0] seg;
    logic [5:0] an;
    logic dp;
    pos   = ((n - 1) / s) % 6;
    v     = (pos < 2) ? sc : (pos < 4) ? m : h;
    lim   = (pos < 4) ? 59 : 23;
    digit = (pos % 2 == 1) ? v / 10 : v % 10;
    if (v > lim)                               seg = 7'b0111111;
    else if (blank_en && pos == 5 && digit == 0) seg = 7'b1111111;
    else                                       seg = seg_tbl[digit];
    an      = 6'b111111;
    an[pos] = 1'b0;
    dp      = !((pos == 4 || pos == 2) && (sc % 2 == 0));
    return {an, seg, dp};
  endfunction

  function automatic logic [13:0] actual(int d);
    if (d == 0) return {an_a, seg_a, dp_a};
    if (d == 1) return {an_b, seg_b, dp_b};
    return {an_c, seg_c, dp_c};
  endfunction

  task automatic check(string name, int n, logic [13:0] act, logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got an_n=%b seg_n=%b dp_n=%b, expected an_n=%b seg_n=%b dp_n=%b",
               name, n, act[13:8], act[7:1], act[0], exp[13:8], exp[7:1], exp[0]);
    end
  endtask

  // Predict every edge while running, then advance the model snapshot at frame ends
  always @(posedge clk) begin
    if (running) begin
      cyc++;
      for (int d = 0; d < 3; d++) begin
        sb.push_back('{d, cyc, model(cyc, scan[d], lb[d], sh[d], sm[d], ss[d])});
        if (cyc % (6 * scan[d]) == 0) begin
          sh[d] = int'(in_hour);
          sm[d] = int'(in_min);
          ss[d] = int'(in_sec);
        end
      end
    end
  end

  // Compare predictions against the pins half a cycle after the edge
  always @(negedge clk) begin
    item_t it;
    if (running) begin
      while (sb.size() > 0) begin
        it = sb.pop_front();
        check($sformatf("dut%0d", it.d), it.cyc, actual(it.d), it.exp);
      end
    end
  end

  task automatic set_time(int h, int m, int s);
    in_hour = 5'(h);
    in_min  = 6'(m);
    in_sec  = 6'(s);
  endtask

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_state(string name);
    for (int d = 0; d < 3; d++)
      check($sformatf("%s dut%0d", name, d), cyc, actual(d), 14'b111111_1111111_1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    for (int d = 0; d < 3; d++) begin
      sh[d] = 0;
      sm[d] = 0;
      ss[d] = 0;
    end
    sb.delete();
    running = 1'b1;
  endtask

  initial begin
    set_time(12, 34, 56);
    run(3);
    check_reset_state("reset_state");
    release_reset();
    run(60);

    // Asynchronous reset pulse between clock edges, mid-frame
    run(5);
    @(posedge clk);
    #2;
    running = 1'b0;
    reset   = 1'b1;
    #1;
    check_reset_state("async_reset");
    run(2);
    release_reset();

    // Input change mid-frame must wait for the frame boundary
    run(30);
    set_time(12, 34, 57);
    run(70);

    // Out-of-range minutes
    set_time(23, 60, 0);
    run(60);

    // Leading blank cases
    set_time(5, 7, 8);
    run(60);
    set_time(0, 59, 59);
    run(60);

    // Randomised times, including out-of-range fields
    for (int i = 0; i < 40; i++) begin
      set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      run($urandom_range(1, 40));
    end
    run(50);

    @(posedge clk);
    #1;
    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
